spi_master_xfer: RTL and testbench
==================================

# spi_master_xfer

Wishbone-attached SPI master byte engine in the management SoC, sitting between the CPU's Wishbone bus and the user-area GPIO pins that drive an external SPI slave (CSB, SCK, SDO, SDI on mprj_io[33:32], [35:34]). Firmware writes a config word and then one byte at a time to a data register. The block serialises each byte onto SDO while sampling SDI, and holds CSB low across bytes in stream mode. Firmware polls busy or takes a completion IRQ.

## Interface
Parameters:
- BASE_ADR, 32'h2400_0000, base address of the register pair
- CFG_OFF, 8'h00, config register offset
- DAT_OFF, 8'h04, data register offset

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset; asynchronous, active-high
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe, cycle, write enable
- wb_sel_i  in  4  byte selects
- wb_adr_i  in  32  address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  ack
- sdi  in  1  serial data from slave
- csb  out  1  chip select, active low unless inverted
- sck  out  1  serial clock
- sdo  out  1  serial data to slave
- sdoenb  out  1  SDO output enable, active low
- irq  out  1  transfer-done pulse

## Operation
- Config register bits: [7:0] prescaler; [8] lsb_first; [9] csb_inv; [10] sck_inv (CPOL=1); [11] sample_falling (CPHA=1); [12] stream; [13] enable; [14] irq_en. Reset value 32'h0000_0002.
- Writes to CFG honour wb_sel_i byte lanes.
- Data register write (sel[0] set) with enable=1 and idle loads tx byte and starts a transfer.
- Data write while busy or with enable=0: data discarded, ack still returned.
- Data register read returns {23'b0, busy, rx[7:0]}. Config read returns config.
- Addresses other than CFG/DAT inside the decoded page ack with read data 0.
- FSM states:
  - IDLE -> (start) -> ASSERT.
  - ASSERT: csb active for one half-period; first bit on sdo. -> SHIFT.
  - SHIFT: 16 half-periods; sample edge captures sdi, launch edge drives next bit. -> DONE.
  - DONE: rx latched, busy cleared, irq pulse if irq_en. -> IDLE.
- CSB release: in DONE when stream=0. With stream=1, csb stays active until firmware clears stream; it then deasserts the cycle after the config write while idle.
- sdoenb is 0 whenever csb is active, 1 otherwise.
- enable cleared mid-transfer: abort; csb inactive and sck idle next cycle; rx unchanged; no irq.

## Timing
- Half-period = prescaler+1 wb_clk_i cycles. prescaler 0 is treated as 1, so minimum sck = clk/4.
- Byte time = 16 half-periods plus one ASSERT half-period when csb was inactive. Back-to-back stream bytes skip ASSERT.
- wb_ack_o is high exactly one cycle, the cycle after stb&cyc is first sampled. It is never asserted on consecutive cycles.
- busy is set the cycle after the data-write ack.
- irq is high one cycle, in the same cycle busy falls.
- Reset values: csb=1 (inactive), sck=0, sdo=0, sdoenb=1, irq=0, wb_ack_o=0, wb_dat_o=0, rx=0, busy=0.
- Reset mid-transfer returns to IDLE immediately, asynchronously, with reset values.
- Simultaneous config write and transfer completion: DONE completes using the old config; the new config applies from IDLE.

## Configuration
- SPI_XFER_LOOPBACK_EN defined: config bit [15] is loopback. When set, SDI is taken internally from sdo and external sdi is ignored.
- SPI_XFER_LOOPBACK_EN undefined: bit [15] reads 0, writes to it are ignored, and no mux is present.

## Test plan
- Reset: hold wb_rst_i high for 5 cycles -> csb=1, sck=0, sdoenb=1, config reads 32'h0000_0002, data reads 0.
- Single byte, mode 0, msb-first, prescaler 2: write 0x9F with slave returning 0x93 -> sdo bit order 1,0,0,1,1,1,1,1. The byte takes (1+16)*3 cycles after busy rises. Data reads 0x093, csb high after DONE, one irq pulse.
- Stream read: stream=1, send 0x03,0x00,0x00,0x00, then four dummy bytes against the flash model -> rx sequence after the address bytes matches flash bytes 0x93,0x01,0x00,0x13. csb stays low throughout, then goes high after stream is cleared.
- Modes: sck_inv=1, sample_falling=1, lsb_first=1, send 0xA5 -> sck idles high, sdo order 1,0,1,0,0,1,0,1, loopback (if compiled) rx=0xA5.
- Busy write: write 0x11, then 0x22 while busy -> only 0x11 shifted out; both writes acked in one cycle each.
- Abort: clear enable at half-period 5 -> csb inactive next cycle, no irq, rx holds previous value; a later transfer completes normally.

Source files
------------

// File: rtl/spi_master_xfer.sv
// Wishbone-attached SPI master byte engine: config + data register pair, one byte per transfer.
// Optional feature: define SPI_XFER_LOOPBACK_EN to add config bit [15] (internal sdo->sdi loopback).
module spi_master_xfer #(
  parameter logic [31:0] BASE_ADR = 32'h2400_0000,
  parameter logic [7:0]  CFG_OFF  = 8'h00,
  parameter logic [7:0]  DAT_OFF  = 8'h04
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        sdi,
  output logic        csb,
  output logic        sck,
  output logic        sdo,
  output logic        sdoenb,
  output logic        irq
);

`ifdef SPI_XFER_LOOPBACK_EN
  localparam logic [15:0] CfgMask = 16'hFFFF;
`else
  localparam logic [15:0] CfgMask = 16'h7FFF;
`endif

  typedef enum logic [1:0] {StIdle, StAssert, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cfg_q, cfg_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  half_q, half_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic        busy_q, busy_d, irq_q, irq_d, cs_act_q, cs_act_d, sck_q, sck_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d, rdata;

  logic [7:0] presc, hp_max;
  logic       lsb_first, csb_inv, sck_inv, cpha, stream, en, irq_en, sdi_int, hp_end;
  logic       req, wr_acc, wr_cfg, wr_dat, start;
  logic       unused_bits;

  assign presc     = cfg_q[7:0];
  assign lsb_first = cfg_q[8];
  assign csb_inv   = cfg_q[9];
  assign sck_inv   = cfg_q[10];
  assign cpha      = cfg_q[11];
  assign stream    = cfg_q[12];
  assign en        = cfg_q[13];
  assign irq_en    = cfg_q[14];
  assign hp_max    = (presc == 8'd0) ? 8'd1 : presc;
  assign hp_end    = (div_q == hp_max);

`ifdef SPI_XFER_LOOPBACK_EN
  assign sdi_int = cfg_q[15] ? sdo : sdi;
`else
  assign sdi_int = sdi;
`endif

  assign unused_bits = ^{wb_sel_i[3:2], wb_dat_i[31:16]};

  // Register side effects land on the edge that closes the ack cycle.
  assign req    = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADR[31:8]);
  assign ack_d  = req & ~ack_q;
  assign wr_acc = req & wb_we_i & ack_q;
  assign wr_cfg = wr_acc & (wb_adr_i[7:0] == CFG_OFF);
  assign wr_dat = wr_acc & (wb_adr_i[7:0] == DAT_OFF) & wb_sel_i[0];
  assign start  = wr_dat & en & (state_q == StIdle);

  always_comb begin
    rdata = 32'h0;
    if (wb_adr_i[7:0] == CFG_OFF) begin
      rdata = {16'h0, cfg_q};
    end else if (wb_adr_i[7:0] == DAT_OFF) begin
      rdata = {23'h0, busy_q, rx_q};
    end
  end

  always_comb begin
    dat_d = ack_d ? rdata : 32'h0;
    cfg_d = cfg_q;
    if (wr_cfg) begin
      if (wb_sel_i[0]) cfg_d[7:0] = wb_dat_i[7:0];
      if (wb_sel_i[1]) cfg_d[15:8] = wb_dat_i[15:8];
      cfg_d = cfg_d & CfgMask;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    tx_sh_d  = tx_sh_q;
    rx_sh_d  = rx_sh_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    irq_d    = 1'b0;
    cs_act_d = cs_act_q;
    sck_d    = sck_q;
    unique case (state_q)
      StIdle: begin
        div_d  = 8'd0;
        half_d = 4'd0;
        sck_d  = 1'b0;
        if (start) begin
          tx_sh_d  = wb_dat_i[7:0];
          busy_d   = 1'b1;
          cs_act_d = 1'b1;
          // A stream byte with csb already active skips the setup half-period.
          state_d  = cs_act_q ? StShift : StAssert;
        end else if (cs_act_q && (!stream || !en)) begin
          cs_act_d = 1'b0;
        end
      end
      StAssert: begin
        div_d = div_q + 8'd1;
        if (hp_end) begin
          div_d   = 8'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        div_d = div_q + 8'd1;
        if (hp_end) begin
          div_d  = 8'd0;
          half_d = half_q + 4'd1;
          sck_d  = ~sck_q;
          if (half_q[0] == cpha) begin
            rx_sh_d = lsb_first ? {sdi_int, rx_sh_q[7:1]} : {rx_sh_q[6:0], sdi_int};
          end else if (cpha ? (half_q != 4'd0) : (half_q != 4'd15)) begin
            tx_sh_d = lsb_first ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
          end
          if (half_q == 4'd15) begin
            state_d = StDone;
            rx_d    = rx_sh_d;
            busy_d  = 1'b0;
            irq_d   = irq_en;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!stream) cs_act_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    // Abort: enable dropped while a byte is in flight.
    if (!en && (state_q != StIdle)) begin
      state_d  = StIdle;
      cs_act_d = 1'b0;
      sck_d    = 1'b0;
      busy_d   = 1'b0;
      irq_d    = 1'b0;
      rx_d     = rx_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cfg_q    <= 16'h0002;
      div_q    <= 8'd0;
      half_q   <= 4'd0;
      tx_sh_q  <= 8'd0;
      rx_sh_q  <= 8'd0;
      rx_q     <= 8'd0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
      cs_act_q <= 1'b0;
      sck_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      div_q    <= div_d;
      half_q   <= half_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      irq_q    <= irq_d;
      cs_act_q <= cs_act_d;
      sck_q    <= sck_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign csb      = cs_act_q ? csb_inv : ~csb_inv;
  assign sck      = sck_q ^ sck_inv;
  assign sdo      = lsb_first ? tx_sh_q[0] : tx_sh_q[7];
  assign sdoenb   = ~cs_act_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Scoreboard bench for spi_master_xfer: Wishbone reads and SPI bytes checked by monitors.
module tb_spi_master_xfer;
  localparam logic [31:0] Base = 32'h2400_0000;
  localparam logic [7:0]  Cfg  = 8'h00;
  localparam logic [7:0]  Dat  = 8'h04;

  logic        clk = 1'b0, wb_rst_i = 1'b1;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_adr_i = 32'h0, wb_dat_i = 32'h0, wb_dat_o;
  logic        wb_ack_o, sdi = 1'b0, csb, sck, sdo, sdoenb, irq;

  int n_chk = 0, n_fail = 0;
  int irq_cnt = 0, cyc = 0, t_cs = 0, t_sck = 0, edges = 0;
  logic cpol = 1'b0, cpha = 1'b0;
  logic [31:0] rd_q[$];
  string       rd_nm[$];
  logic [7:0]  spi_q[$];
  logic [7:0]  slave_q[$];

  spi_master_xfer #(.BASE_ADR(Base), .CFG_OFF(Cfg), .DAT_OFF(Dat)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .sdi(sdi), .csb(csb), .sck(sck), .sdo(sdo),
    .sdoenb(sdoenb), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Read monitor: pops the expected read data whenever a read is acked.
  initial forever begin
    @(negedge clk);
    if (wb_ack_o && !wb_we_i) begin
      if (rd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rd_unexpected: got %h expected none", wb_dat_o);
      end else begin
        check(rd_nm.pop_front(), wb_dat_o, rd_q.pop_front());
      end
    end
  end

  // IRQ monitor: counts pulses and requires each to be one cycle wide.
  initial begin
    logic prev_irq = 1'b0;
    forever begin
      @(negedge clk);
      if (irq) begin
        irq_cnt++;
        check("irq_one_cycle", {31'h0, prev_irq}, 32'h0);
      end
      prev_irq = irq;
    end
  end

  // SPI slave monitor: drives sdi from slave_q and collects sdo bits in time order.
  initial begin
    logic prev_sck = 1'b0, prev_act = 1'b0, act;
    logic [7:0] seq = 8'h0, cur = 8'h0;
    int bitcnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      act = ~csb;
      if (act && !prev_act) begin
        bitcnt = 0; t_cs = cyc; edges = 0;
        cur = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
        sdi = cur[7];
      end
      if (act && (sck != prev_sck)) begin
        t_sck = cyc;
        edges++;
        if ((prev_sck == cpol) ^ cpha) begin
          seq = {seq[6:0], sdo};
          bitcnt++;
          if (bitcnt == 8) begin
            if (spi_q.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL spi_unexpected_byte: got %h expected none", seq);
            end else begin
              check("spi_sdo_order", {24'h0, seq}, {24'h0, spi_q.pop_front()});
            end
            bitcnt = 0;
            cur = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
            sdi = cur[7];
          end else begin
            sdi = cur[7-bitcnt];
          end
        end
      end
      prev_sck = sck;
      prev_act = act;
    end
  end

  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] d,
                         input logic [3:0] sel);
    int n = 0;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = Base | {24'h0, off}; wb_dat_i = d; wb_sel_i = sel;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 20);
    check("ack_latency", n, 1);
    @(posedge clk); #1;
    check("ack_not_consecutive", {31'h0, wb_ack_o}, 32'h0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    rd_q.push_back(exp);
    rd_nm.push_back(name);
    wb_xfer(1'b0, off, 32'h0, 4'hF);
  endtask

  task automatic wait_irq(input string name);
    int start = irq_cnt;
    int n = 0;
    while (irq_cnt == start && n < 2000) begin
      @(posedge clk); n++;
    end
    check(name, irq_cnt - start, 1);
  endtask

  initial begin
    logic [7:0] tx_s [8] = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] rx_s [8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h93, 8'h01, 8'h00, 8'h13};
    int n, irq_before;

    repeat (5) @(posedge clk);
    #1;
    check("rst_csb", {31'h0, csb}, 32'h1);
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_sdo", {31'h0, sdo}, 32'h0);
    check("rst_sdoenb", {31'h0, sdoenb}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ack", {31'h0, wb_ack_o}, 32'h0);
    check("rst_dat_o", wb_dat_o, 32'h0);
    @(negedge clk);
    wb_rst_i = 1'b0;
    wb_read(Cfg, 32'h0000_0002, "rd_cfg_reset");
    wb_read(Dat, 32'h0000_0000, "rd_dat_reset");
    wb_read(8'h08, 32'h0000_0000, "rd_unmapped");

    // Data write with enable=0 is discarded.
    wb_xfer(1'b1, Dat, 32'h0000_0077, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    check("disabled_no_csb", {31'h0, csb}, 32'h1);
    wb_read(Dat, 32'h0000_0000, "rd_dat_disabled");

    // Byte-lane writes: lane 1 only, then bit 15 probe.
    wb_xfer(1'b1, Cfg, 32'hFFFF_6055, 4'b0010);
    wb_read(Cfg, 32'h0000_6002, "rd_cfg_lane1");
    wb_xfer(1'b1, Cfg, 32'h0000_E002, 4'b0011);
`ifdef SPI_XFER_LOOPBACK_EN
    wb_read(Cfg, 32'h0000_E002, "rd_cfg_bit15");
`else
    wb_read(Cfg, 32'h0000_6002, "rd_cfg_bit15");
`endif
    wb_xfer(1'b1, Cfg, 32'h0000_6002, 4'b0011);

    // Single byte, mode 0, msb first, prescaler 2.
    slave_q.push_back(8'h93);
    spi_q.push_back(8'h9F);
    wb_xfer(1'b1, Dat, 32'h0000_009F, 4'hF);
    check("sdoenb_active", {31'h0, sdoenb}, 32'h0);
    wait_irq("irq_single");
    check("byte_time_p2", t_sck - t_cs, 51);
    repeat (2) @(posedge clk);
    #1;
    check("csb_release", {31'h0, csb}, 32'h1);
    wb_read(Dat, 32'h0000_0093, "rd_rx_single");

    // Stream: command + address, then four dummy bytes returning flash data.
    wb_xfer(1'b1, Cfg, 32'h0000_7002, 4'b0011);
    for (int i = 0; i < 8; i++) slave_q.push_back(rx_s[i]);
    for (int i = 0; i < 8; i++) begin
      spi_q.push_back(tx_s[i]);
      wb_xfer(1'b1, Dat, {24'h0, tx_s[i]}, 4'hF);
      wait_irq("irq_stream");
      wb_read(Dat, {24'h0, rx_s[i]}, "rd_rx_stream");
      check("csb_held_stream", {31'h0, csb}, 32'h0);
    end
    wb_xfer(1'b1, Cfg, 32'h0000_6002, 4'b0011);
    check("csb_held_until_idle", {31'h0, csb}, 32'h0);
    @(posedge clk); #1;
    check("csb_stream_release", {31'h0, csb}, 32'h1);

    // Modes: CPOL=1, CPHA=1, lsb first, prescaler 0 (treated as 1).
`ifdef SPI_XFER_LOOPBACK_EN
    wb_xfer(1'b1, Cfg, 32'h0000_ED00, 4'b0011);
`else
    wb_xfer(1'b1, Cfg, 32'h0000_6D00, 4'b0011);
`endif
    cpol = 1'b1; cpha = 1'b1;
    check("sck_idle_high", {31'h0, sck}, 32'h1);
    slave_q.push_back(8'hA5);
    spi_q.push_back(8'hA5);
    wb_xfer(1'b1, Dat, 32'h0000_00A5, 4'hF);
    wait_irq("irq_modes");
    check("byte_time_p0", t_sck - t_cs, 34);
    check("sck_idle_after", {31'h0, sck}, 32'h1);
    wb_read(Dat, 32'h0000_00A5, "rd_rx_modes");
    wb_xfer(1'b1, Cfg, 32'h0000_6002, 4'b0011);
    cpol = 1'b0; cpha = 1'b0;

    // Write while busy is discarded.
    slave_q.push_back(8'h5A);
    spi_q.push_back(8'h11);
    wb_xfer(1'b1, Dat, 32'h0000_0011, 4'hF);
    wb_xfer(1'b1, Dat, 32'h0000_0022, 4'hF);
    wb_read(Dat, 32'h0000_01A5, "rd_busy_flag");
    wait_irq("irq_busy");
    repeat (4) @(posedge clk);
    wb_read(Dat, 32'h0000_005A, "rd_rx_busy");

    // Abort mid-transfer by clearing enable.
    slave_q.push_back(8'h00);
    wb_xfer(1'b1, Dat, 32'h0000_00F0, 4'hF);
    n = 0;
    while (edges < 5 && n < 500) begin
      @(posedge clk); n++;
    end
    check("abort_reached_hp5", {31'h0, edges >= 5}, 32'h1);
    irq_before = irq_cnt;
    wb_xfer(1'b1, Cfg, 32'h0000_4002, 4'b0011);
    @(posedge clk); #1;
    check("abort_csb", {31'h0, csb}, 32'h1);
    check("abort_sck", {31'h0, sck}, 32'h0);
    check("abort_sdoenb", {31'h0, sdoenb}, 32'h1);
    repeat (60) @(posedge clk);
    check("abort_no_irq", irq_cnt, irq_before);
    wb_read(Dat, 32'h0000_005A, "rd_rx_abort");
    wb_xfer(1'b1, Cfg, 32'h0000_6002, 4'b0011);
    slave_q.push_back(8'hC3);
    spi_q.push_back(8'h3C);
    wb_xfer(1'b1, Dat, 32'h0000_003C, 4'hF);
    wait_irq("irq_after_abort");
    repeat (4) @(posedge clk);
    wb_read(Dat, 32'h0000_00C3, "rd_rx_after_abort");

    repeat (4) @(posedge clk);
    check("spi_queue_drained", spi_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
